// File: rtl/cfu_simd_mac_buf_pkg.sv
// Shared opcodes, FSM states and lane widths for the CFU SIMD MAC.
// Imported by the bus interface, the dot-product unit and the top.
package cfu_mac_pkg;

  localparam int LANE_W = 8;
  localparam int PROD_W = 34;
  localparam int DOT_W  = 36;

  localparam logic [6:0] OP_CLR    = 7'd0;
  localparam logic [6:0] OP_SETOFF = 7'd1;
  localparam logic [6:0] OP_LOAD   = 7'd2;
  localparam logic [6:0] OP_MACI   = 7'd3;
  localparam logic [6:0] OP_RUN    = 7'd4;
  localparam logic [6:0] OP_READ   = 7'd5;
  localparam logic [6:0] OP_SAT    = 7'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RUN,
    ST_DRAIN
  } state_e;

  function automatic logic signed [LANE_W-1:0] lane(
    input logic [31:0] w,
    input int          k
  );
    return w[k*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/cfu_simd_mac_buf_if.sv
// VexRiscv CFU command/response bus.
// master = CPU side, slave = CFU side.
interface cfu_simd_mac_buf_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid,
    output cmd_payload_function_id,
    output cmd_payload_inputs_0,
    output cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid,
    input  cmd_payload_function_id,
    input  cmd_payload_inputs_0,
    input  cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_payload_outputs_0
  );

endinterface

// File: rtl/cfu_simd_mac_buf_dot4.sv
// Four int8 lanes: (a+in_off)*(b+filt_off), summed.
// Shared between MACI operands and buffer sweep data.
module cfu_dot4
  import cfu_mac_pkg::*;
#(
  parameter int OFFSET_W = 16
) (
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic [OFFSET_W-1:0]     in_off,
  input  logic [OFFSET_W-1:0]     filt_off,
  output logic signed [DOT_W-1:0] dot
);

  localparam int SW = OFFSET_W + 1;
  localparam int PW = 2 * SW;

  logic signed [SW-1:0] sa;
  logic signed [SW-1:0] sb;
  logic signed [PW-1:0] p;

  // offset-add, multiply and reduce all four lanes
  always_comb begin
    dot = '0;
    sa  = '0;
    sb  = '0;
    p   = '0;
    for (int k = 0; k < 4; k++) begin
      sa  = SW'(lane(a, k)) + SW'($signed(in_off));
      sb  = SW'(lane(b, k)) + SW'($signed(filt_off));
      p   = PW'(sa) * PW'(sb);
      dot = dot + DOT_W'(p);
    end
  end

endmodule

// File: rtl/cfu_simd_mac_buf.sv
// CFU int8 SIMD MAC with offsets and a LOAD/RUN operand buffer.
// Define CFU_MAC_SAT_EN for saturating accumulation and sat flag.
module cfu_simd_mac_buf
  import cfu_mac_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ACC_W    = 32,
  parameter int OFFSET_W = 16,
  parameter int PIPE     = 1
) (
  input  logic               clk,
  input  logic               reset,
  cfu_simd_mac_buf_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(DEPTH);
  localparam int SUM_W = ACC_W + DOT_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef CFU_MAC_SAT_EN
  localparam logic signed [SUM_W-1:0] AMAX =
    (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] AMIN = -AMAX - SUM_W'(1);
`endif

  state_e state, state_n;

  logic [ACC_W-1:0]    acc, acc_n;
  logic [OFFSET_W-1:0] in_off, in_off_n;
  logic [OFFSET_W-1:0] filt_off, filt_off_n;
  logic [CW-1:0]       wr_cnt, wr_cnt_n;
  logic [CW-1:0]       last, rd_ext;
  logic [RW-1:0]       rd_ptr, rd_ptr_n;
  logic                rsp_valid, rsp_valid_n;
  logic [31:0]         rsp_out, rsp_out_n;
  logic                sat, sat_n;
  logic                buf_we;
  logic [63:0]         mem [DEPTH];
  logic [63:0]         rd_word;
  logic [31:0]         dot_a, dot_b;
  logic signed [DOT_W-1:0] dot_c, dot_q;
  logic [ACC_W:0]      step;
  logic [6:0]          op;
  logic                fire, sel_buf, run_done;
  logic                unused_bits;

  function automatic logic [ACC_W:0] acc_step(
    input logic [ACC_W-1:0] a,
    input logic [DOT_W-1:0] d
  );
    logic [SUM_W-1:0] s;
    s = {{DOT_W{a[ACC_W-1]}}, a} + {{ACC_W{d[DOT_W-1]}}, d};
`ifdef CFU_MAC_SAT_EN
    if ($signed(s) > AMAX)
      return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    if ($signed(s) < AMIN)
      return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
`endif
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign op      = bus.cmd_payload_function_id[9:3];
  assign unused_bits = ^{bus.cmd_payload_function_id[2:0], sat};

  assign bus.cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_payload_outputs_0 = rsp_out;
  assign fire = bus.cmd_valid && bus.cmd_ready;

  assign sel_buf = (state == ST_RUN) || (state == ST_DRAIN);
  assign rd_word = mem[rd_ptr];
  assign dot_a   = sel_buf ? rd_word[31:0]  : bus.cmd_payload_inputs_0;
  assign dot_b   = sel_buf ? rd_word[63:32] : bus.cmd_payload_inputs_1;

  cfu_dot4 #(.OFFSET_W(OFFSET_W)) u_dot4 (
    .a        (dot_a),
    .b        (dot_b),
    .in_off   (in_off),
    .filt_off (filt_off),
    .dot      (dot_c)
  );

  generate
    if (PIPE != 0) begin : g_pipe
      // product register between dot unit and accumulator
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) dot_q <= '0;
        else        dot_q <= dot_c;
      end
    end else begin : g_comb
      assign dot_q = dot_c;
    end
  endgenerate

  assign step   = acc_step(acc, dot_q);
  assign last   = wr_cnt - CW'(1);
  assign rd_ext = CW'(rd_ptr);
  assign run_done = (PIPE != 0) ? (rd_ext == last)
                                : (rd_ext + CW'(1) == last);

  // operand buffer: write-only from LOAD, no reset needed
  always_ff @(posedge clk) begin
    if (buf_we) mem[wr_cnt[RW-1:0]] <= {bus.cmd_payload_inputs_1,
                                        bus.cmd_payload_inputs_0};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // next state, datapath updates and response
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    in_off_n    = in_off;
    filt_off_n  = filt_off;
    wr_cnt_n    = wr_cnt;
    rd_ptr_n    = rd_ptr;
    rsp_valid_n = rsp_valid;
    rsp_out_n   = rsp_out;
    sat_n       = sat;
    buf_we      = 1'b0;

    if (rsp_valid && bus.rsp_ready) rsp_valid_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fire) begin
          rsp_valid_n = 1'b1;
          rsp_out_n   = '0;
          unique case (1'b1)
            (op == OP_CLR): begin
              acc_n = '0;
              sat_n = 1'b0;
            end
            (op == OP_SETOFF): begin
              in_off_n   = bus.cmd_payload_inputs_0[OFFSET_W-1:0];
              filt_off_n = bus.cmd_payload_inputs_1[OFFSET_W-1:0];
              acc_n      = '0;
              wr_cnt_n   = '0;
              sat_n      = 1'b0;
            end
            (op == OP_LOAD): begin
              if (wr_cnt == FULL) begin
                rsp_out_n = '1;
              end else begin
                buf_we    = 1'b1;
                wr_cnt_n  = wr_cnt + CW'(1);
                rsp_out_n = 32'(wr_cnt + CW'(1));
              end
            end
            (op == OP_MACI): begin
              if (PIPE != 0) begin
                rsp_valid_n = 1'b0;
                state_n     = ST_EXEC;
              end else begin
                acc_n     = step[ACC_W-1:0];
                sat_n     = sat | step[ACC_W];
                rsp_out_n = step[31:0];
              end
            end
            (op == OP_RUN): begin
              if (wr_cnt != '0) begin
                rsp_valid_n = 1'b0;
                rd_ptr_n    = '0;
                state_n     = (PIPE == 0 && wr_cnt == CW'(1))
                              ? ST_DRAIN : ST_RUN;
              end else begin
                rsp_out_n = acc[31:0];
              end
            end
            (op == OP_READ): begin
              rsp_out_n = acc[31:0];
`ifdef CFU_MAC_SAT_EN
              if (ACC_W > 32) rsp_out_n = {acc[31:1], sat};
`endif
            end
`ifdef CFU_MAC_SAT_EN
            (op == OP_SAT): begin
              rsp_out_n = {31'b0, sat};
            end
`endif
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        acc_n       = step[ACC_W-1:0];
        sat_n       = sat | step[ACC_W];
        rsp_valid_n = 1'b1;
        rsp_out_n   = step[31:0];
        state_n     = ST_IDLE;
      end
      ST_RUN: begin
        if (PIPE == 0 || rd_ptr != '0) begin
          acc_n = step[ACC_W-1:0];
          sat_n = sat | step[ACC_W];
        end
        if (run_done) begin
          state_n = ST_DRAIN;
          if (PIPE == 0) rd_ptr_n = rd_ptr + RW'(1);
        end else begin
          rd_ptr_n = rd_ptr + RW'(1);
        end
      end
      ST_DRAIN: begin
        acc_n       = step[ACC_W-1:0];
        sat_n       = sat | step[ACC_W];
        rsp_valid_n = 1'b1;
        rsp_out_n   = step[31:0];
        wr_cnt_n    = '0;
        state_n     = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // datapath and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      in_off    <= '0;
      filt_off  <= '0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      sat       <= 1'b0;
    end else begin
      acc       <= acc_n;
      in_off    <= in_off_n;
      filt_off  <= filt_off_n;
      wr_cnt    <= wr_cnt_n;
      rd_ptr    <= rd_ptr_n;
      rsp_valid <= rsp_valid_n;
      rsp_out   <= rsp_out_n;
      sat       <= sat_n;
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac_buf.sv
// Scoreboard bench for cfu_simd_mac_buf.
// Expected responses are queued at issue and popped on response.
module tb_cfu_simd_mac_buf;

  localparam int DEPTH = 16;
  localparam int PIPE  = 1;

  localparam logic [6:0] T_CLR    = 7'd0;
  localparam logic [6:0] T_SETOFF = 7'd1;
  localparam logic [6:0] T_LOAD   = 7'd2;
  localparam logic [6:0] T_MACI   = 7'd3;
  localparam logic [6:0] T_RUN    = 7'd4;
  localparam logic [6:0] T_READ   = 7'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cfu_simd_mac_buf_if bus();

  cfu_simd_mac_buf #(
    .DEPTH(DEPTH), .ACC_W(32), .OFFSET_W(16), .PIPE(PIPE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] r_data;
  int          r_lat;
  int          m_acc, m_io, m_fo, m_cnt;
  logic [31:0] m_a[DEPTH];
  logic [31:0] m_b[DEPTH];

  function automatic longint dot_m(input logic [31:0] a, b,
                                   input int io, fo);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += (longint'($signed(a[8*k +: 8])) + io) *
           (longint'($signed(b[8*k +: 8])) + fo);
    return s;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [31:0] a, b,
                       input logic [2:0] lo = 3'd0);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {op, lo};
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    r_lat = 1;
    while (!bus.rsp_valid && r_lat < 1000) begin
      @(posedge clk);
      #1 r_lat++;
    end
    r_data = bus.rsp_payload_outputs_0;
    checks++;
    if (!bus.rsp_valid) begin
      errors++;
      $display("FAIL timeout op=%0d: no rsp after %0d cycles", op, r_lat);
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_payload_outputs_0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b d=%h want v=0 d=0",
               bus.rsp_valid, bus.rsp_payload_outputs_0);
    end
    @(negedge clk) reset = 1'b1;
    m_acc = 0; m_io = 0; m_fo = 0; m_cnt = 0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
    end
    exp_q.push_back(32'd0);
    issue(T_READ, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL reset_acc: got %h want %h", r_data, e);
    end
  endtask

  task automatic test_maci();
    logic [31:0] a, b;
    m_io = 128; m_fo = 0; m_acc = 0; m_cnt = 0;
    exp_q.push_back(32'd0);
    issue(T_SETOFF, 32'd128, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != 1) begin
      errors++;
      $display("FAIL setoff: got %h lat %0d want %h lat 1", r_data, r_lat, e);
    end
    exp_q.push_back(32'd522);
    issue(T_MACI, 32'h01020304, 32'h01010101); take_rsp();
    m_acc = 522;
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != 1 + PIPE) begin
      errors++;
      $display("FAIL maci_522: got %h lat %0d want %h lat %0d",
               r_data, r_lat, e, 1 + PIPE);
    end
    for (int t = 0; t < 4; t++) begin
      a = $urandom; b = $urandom;
      m_io = int'($signed(a[15:0])); m_fo = int'($signed(b[15:0]));
      m_acc = 0; m_cnt = 0;
      exp_q.push_back(32'd0);
      issue(T_SETOFF, a, b); take_rsp();
      e = exp_q.pop_front(); checks++;
      if (r_data !== e) begin
        errors++; $display("FAIL setoff_rand: got %h want %h", r_data, e);
      end
      for (int j = 0; j < 3; j++) begin
        a = $urandom; b = $urandom;
        m_acc = m_acc + int'(dot_m(a, b, m_io, m_fo));
        exp_q.push_back(32'(m_acc));
        issue(T_MACI, a, b, 3'(j + 5)); take_rsp();
        e = exp_q.pop_front(); checks++;
        if (r_data !== e) begin
          errors++; $display("FAIL maci_rand: got %h want %h", r_data, e);
        end
      end
    end
  endtask

  task automatic test_run();
    m_io = 0; m_fo = 0; m_acc = 0; m_cnt = 0;
    exp_q.push_back(32'd0);
    issue(T_SETOFF, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'(i + 1));
      issue(T_LOAD, 32'h7F7F7F7F, 32'h81818181); take_rsp();
      e = exp_q.pop_front(); checks++;
      if (r_data !== e || r_lat != 1) begin
        errors++;
        $display("FAIL load_cnt: got %h lat %0d want %h lat 1",
                 r_data, r_lat, e);
      end
    end
    exp_q.push_back(32'hFFFD_0BF4);
    issue(T_RUN, 32'd0, 32'd0); take_rsp();
    m_acc = -193548;
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != 3 + PIPE + 1) begin
      errors++;
      $display("FAIL run3: got %h lat %0d want %h lat %0d",
               r_data, r_lat, e, 3 + PIPE + 1);
    end
  endtask

  task automatic test_load_full();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    m_io = int'($signed(a[15:0])); m_fo = int'($signed(b[15:0]));
    m_acc = 0; m_cnt = 0;
    exp_q.push_back(32'd0);
    issue(T_SETOFF, a, b); take_rsp();
    e = exp_q.pop_front();
    for (int i = 0; i <= DEPTH; i++) begin
      a = $urandom; b = $urandom;
      if (m_cnt < DEPTH) begin
        m_a[m_cnt] = a; m_b[m_cnt] = b; m_cnt++;
        exp_q.push_back(32'(m_cnt));
      end else begin
        exp_q.push_back(32'hFFFF_FFFF);
      end
      issue(T_LOAD, a, b); take_rsp();
      e = exp_q.pop_front(); checks++;
      if (r_data !== e) begin
        errors++; $display("FAIL load_full[%0d]: got %h want %h", i, r_data, e);
      end
    end
    for (int i = 0; i < DEPTH; i++)
      m_acc = m_acc + int'(dot_m(m_a[i], m_b[i], m_io, m_fo));
    m_cnt = 0;
    exp_q.push_back(32'(m_acc));
    issue(T_RUN, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != DEPTH + PIPE + 1) begin
      errors++;
      $display("FAIL run_full: got %h lat %0d want %h lat %0d",
               r_data, r_lat, e, DEPTH + PIPE + 1);
    end
  endtask

  task automatic test_run_empty();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    m_acc = m_acc + int'(dot_m(a, b, m_io, m_fo));
    exp_q.push_back(32'(m_acc));
    issue(T_MACI, a, b); take_rsp();
    e = exp_q.pop_front();
    exp_q.push_back(32'(m_acc));
    issue(T_RUN, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != 1) begin
      errors++;
      $display("FAIL run_empty: got %h lat %0d want %h lat 1", r_data, r_lat, e);
    end
    exp_q.push_back(32'(m_acc));
    issue(T_READ, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL read_after_empty: got %h want %h", r_data, e);
    end
  endtask

  task automatic test_others();
    exp_q.push_back(32'd0);
    issue(7'd7, 32'hDEAD_BEEF, 32'h1234_5678, 3'd5); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e || r_lat != 1) begin
      errors++; $display("FAIL op7: got %h lat %0d want %h", r_data, r_lat, e);
    end
    exp_q.push_back(32'd0);
    issue(7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL op7f: got %h want %h", r_data, e);
    end
    exp_q.push_back(32'(m_acc));
    issue(T_READ, 32'd0, 32'd0, 3'd7); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL read_kept: got %h want %h", r_data, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, d;
    a = $urandom; b = $urandom;
    m_acc = m_acc + int'(dot_m(a, b, m_io, m_fo));
    exp_q.push_back(32'(m_acc));
    issue(T_MACI, a, b);
    d = r_data;
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin
      errors++; $display("FAIL bp_data: got %h want %h", d, e);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {T_CLR, 3'd0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_payload_outputs_0 !== d ||
          bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                 i, bus.rsp_valid, bus.rsp_payload_outputs_0, bus.cmd_ready, d);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1",
               bus.rsp_valid, bus.cmd_ready);
    end
    m_acc = 0;
    exp_q.push_back(32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_payload_outputs_0 !== e) begin
      errors++;
      $display("FAIL bp_next_cmd: got v=%b d=%h want v=1 d=%h",
               bus.rsp_valid, bus.rsp_payload_outputs_0, e);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'(m_cnt + 1));
      issue(T_LOAD, $urandom, $urandom); take_rsp();
      m_cnt++;
      e = exp_q.pop_front();
    end
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {T_RUN, 3'd0};
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1",
               bus.rsp_valid, bus.cmd_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_acc = 0; m_cnt = 0; m_io = 0; m_fo = 0;
    repeat (15) @(posedge clk);
    #1 checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL no_rsp_after_reset: got %b want 0", bus.rsp_valid);
    end
    exp_q.push_back(32'd0);
    issue(T_READ, 32'd0, 32'd0); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL read_after_reset: got %h want %h", r_data, e);
    end
    exp_q.push_back(32'd1);
    issue(T_LOAD, 32'd1, 32'd1); take_rsp();
    e = exp_q.pop_front(); checks++;
    if (r_data !== e) begin
      errors++; $display("FAIL wr_cnt_after_reset: got %h want %h", r_data, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 3) begin
        m_acc = 0;
        exp_q.push_back(32'd0);
        issue(T_CLR, a, b);
      end else begin
        m_acc = m_acc + int'(dot_m(a, b, m_io, m_fo));
        exp_q.push_back(32'(m_acc));
        issue(T_MACI, a, b);
      end
      take_rsp();
      e = exp_q.pop_front(); checks++;
      if (r_data !== e) begin
        errors++; $display("FAIL b2b[%0d]: got %h want %h", i, r_data, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_maci();
    test_run();
    test_load_full();
    test_run_empty();
    test_others();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
